ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard. It is the counterpart of the existing receive-only ps2 block. It shares the open-drain ps2_clk/ps2_data pins, which are tristated at top level from this block's drive-low outputs. It reports device ACK or failure, and raises busy so the receiver ignores the transaction.

Parameters:
CLK_HZ, 74_250_000, system clock frequency
INHIBIT_US, 120, time the clock is held low before the request-to-send
TIMEOUT_US, 15_000, maximum time from clock release to ACK completion
FILTER_CYCLES, 8, stable cycles required on the clock line (only used with PS2_TX_FILTER_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
command_valid  in  1  command byte offered
command_ready  out  1  block accepts a command this cycle
command_byte  in  8  byte to send
ps2_clk_in  in  1  raw pin level (asynchronous)
ps2_data_in  in  1  raw pin level (asynchronous)
ps2_clk_drive_low  out  1  1 = pull the clock line low
ps2_data_drive_low  out  1  1 = pull the data line low
busy  out  1  high from accept until return to IDLE
result_valid  out  1  one-cycle pulse at end of transaction
result_error  out  1  qualified by result_valid: 1 = NACK or timeout

Behaviour:
- Reset (async, active-high): state=IDLE; both drive_low=0; busy=0; result_valid=0; result_error=0; command_ready=1 after deassert. Reset mid-transaction releases both lines immediately.
- Inputs: 2-flop synchronizers on both lines. A falling edge is a synchronized clock-line transition from 1 to 0.
- command_ready=1 only in IDLE. A transfer fires on valid&&ready; the byte is latched; parity = ~^byte (odd parity).
- IDLE -> INHIBIT on transfer:
  - clk_drive_low=1, busy=1.
  - Hold for CLK_HZ*INHIBIT_US/1e6 cycles.
- INHIBIT -> REQUEST:
  - data_drive_low=1 (start bit), then clk_drive_low=0 on the following cycle.
  - Timeout counter starts.
- REQUEST/SHIFT:
  - Edge counter n counts device falling edges.
  - Edges 1..8: data_drive_low = ~byte[n-1] (LSB first), updated the cycle after the edge.
  - Edge 9: drive ~parity.
  - Edge 10: data_drive_low=0 (stop bit, line released).
- ACK:
  - On falling edge 11, sample synchronized data: 0 = ACK, 1 = NACK.
  - Then go to RELEASE.
- RELEASE:
  - Wait until both synchronized lines read 1.
  - Pulse result_valid with result_error = NACK.
  - Go to IDLE; busy drops the same cycle.
- Timeout:
  - Applies if CLK_HZ*TIMEOUT_US/1e6 cycles elapse after clock release without reaching IDLE.
  - Release both lines, pulse result_valid with result_error=1, go to IDLE.
  - Timeout takes priority over a same-cycle edge.
- Counter width is $clog2 of the largest count. Comparisons are terminal-count (count == N-1); no wrap.
- command_valid while busy is ignored (ready=0). The upstream holds valid per the standard valid/ready rule.
- The block never drives a line high; it only releases it.

Optional Feature:
- PS2_TX_FILTER_EN:
  - Defined: a clock-line level is accepted only after FILTER_CYCLES consecutive identical synchronized samples. Edges are derived from the filtered level, adding FILTER_CYCLES latency.
  - Undefined: edges come straight from the 2-flop synchronizer output.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE);
  - odd-parity function;
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF;
  - ACK byte 8'hFA.
- One sub-module, ps2_line_sync: synchronizer, optional filter, falling-edge strobe. The existing receiver can reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACK low -> clk held low ≥8910 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released; result_valid with result_error=0.
- Send 0xF4 -> parity bit 0 on edge 9; send 0x00 -> parity 1; bits checked at each device rising edge.
- Device leaves data high at the ACK edge -> result_error=1 pulse, both lines released, command_ready=1 next cycle.
- Device never clocks -> after 1,113,750 cycles: result_error=1, drive_low both 0, IDLE.
- Assert reset at edge 5 -> both drive_low=0 within the reset assertion (async), busy=0.
- Assert command_valid while busy with a second byte -> not accepted; accepted only after result_valid; bytes are sent in order.
- With PS2_TX_FILTER_EN: a 3-cycle low glitch on the clock line is not counted as an edge.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, command bytes, parity helper.
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_INHIBIT = 3'd1;
  localparam state_t S_REQUEST = 3'd2;
  localparam state_t S_SHIFT   = 3'd3;
  localparam state_t S_ACK     = 3'd4;
  localparam state_t S_RELEASE = 3'd5;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pin synchronizer with clock falling-edge strobe.
// Define PS2_TX_FILTER_EN to add a glitch filter on the clock line.
module ps2_line_sync #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_line_i,
  input  logic data_line_i,
  output logic clk_o,
  output logic data_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       lvl;
  logic       prev_q;

  if (FILTER_CYCLES == 0) begin : g_bad_filter
    $error("FILTER_CYCLES must be at least 1");
  end

  // Idle PS/2 lines float high, so reset to 1 avoids a false edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      prev_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], clk_line_i};
      data_sync_q <= {data_sync_q[0], data_line_i};
      prev_q      <= lvl;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int unsigned FW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FW-1:0] FLT_TC = FW'(FILTER_CYCLES - 1);

  logic [FW-1:0] flt_cnt_q;
  logic [FW-1:0] flt_cnt_d;
  logic          flt_q;
  logic          flt_d;

  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_sync_q[1] != flt_q) begin
      if (flt_cnt_q == FLT_TC) flt_d = clk_sync_q[1];
      else flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      flt_q     <= flt_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = clk_sync_q[1];
`endif

  assign clk_o      = lvl;
  assign data_o     = data_sync_q[1];
  assign clk_fall_o = prev_q & ~lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain drive-low outputs).
// Optional PS2_TX_FILTER_EN enables clock-line glitch filtering in ps2_line_sync.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 74_250_000,
  parameter int unsigned INHIBIT_US    = 120,
  parameter int unsigned TIMEOUT_US    = 15_000,
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       command_valid,
  output logic       command_ready,
  input  logic [7:0] command_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       result_valid,
  output logic       result_error
);

  localparam longint unsigned INH_CYC =
    (64'(CLK_HZ) * 64'(INHIBIT_US)) / 64'd1_000_000;
  localparam longint unsigned TMO_CYC =
    (64'(CLK_HZ) * 64'(TIMEOUT_US)) / 64'd1_000_000;
  localparam longint unsigned CNT_MAX =
    (INH_CYC > TMO_CYC) ? INH_CYC : TMO_CYC;
  localparam int unsigned CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] INH_TC = CW'(INH_CYC - 64'd1);
  localparam logic [CW-1:0] TMO_TC = CW'(TMO_CYC - 64'd1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_n_q, bit_n_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic          clk_lo_q, clk_lo_d;
  logic          dat_lo_q, dat_lo_d;
  logic          nack_q, nack_d;
  logic          rv_q, rv_d;
  logic          re_q, re_d;

  logic clk_s, data_s, clk_fall;
  logic in_xfer, timed_out;

  ps2_line_sync #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync (
    .clk_i      (clk),
    .rst_i      (reset),
    .clk_line_i (ps2_clk_in),
    .data_line_i(ps2_data_in),
    .clk_o      (clk_s),
    .data_o     (data_s),
    .clk_fall_o (clk_fall)
  );

  assign in_xfer = (state_q == S_SHIFT) ||
                   (state_q == S_ACK)   ||
                   (state_q == S_RELEASE);
  assign timed_out = in_xfer && (cnt_q == TMO_TC);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_n_d  = bit_n_q;
    byte_d   = byte_q;
    par_d    = par_q;
    clk_lo_d = clk_lo_q;
    dat_lo_d = dat_lo_q;
    nack_d   = nack_q;
    rv_d     = 1'b0;
    re_d     = re_q;
    unique case (state_q)
      S_IDLE: begin
        if (command_valid) begin
          byte_d   = command_byte;
          par_d    = odd_parity(command_byte);
          clk_lo_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_TC) begin
          dat_lo_d = 1'b1;
          state_d  = S_REQUEST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQUEST: begin
        clk_lo_d = 1'b0;
        cnt_d    = '0;
        bit_n_d  = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_fall) begin
          bit_n_d = bit_n_q + 4'd1;
          if (bit_n_q < 4'd8) begin
            dat_lo_d = ~byte_q[bit_n_q[2:0]];
          end else if (bit_n_q == 4'd8) begin
            dat_lo_d = ~par_q;
          end else begin
            dat_lo_d = 1'b0;
            state_d  = S_ACK;
          end
        end
      end
      S_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_fall) begin
          nack_d  = data_s;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_s && data_s) begin
          rv_d    = 1'b1;
          re_d    = nack_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Timeout wins over any same-cycle edge or completion
    if (timed_out) begin
      clk_lo_d = 1'b0;
      dat_lo_d = 1'b0;
      rv_d     = 1'b1;
      re_d     = 1'b1;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_n_q  <= '0;
      byte_q   <= '0;
      par_q    <= 1'b0;
      clk_lo_q <= 1'b0;
      dat_lo_q <= 1'b0;
      nack_q   <= 1'b0;
      rv_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_n_q  <= bit_n_d;
      byte_q   <= byte_d;
      par_q    <= par_d;
      clk_lo_q <= clk_lo_d;
      dat_lo_q <= dat_lo_d;
      nack_q   <= nack_d;
      rv_q     <= rv_d;
      re_q     <= re_d;
    end
  end

  assign command_ready      = (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign ps2_clk_drive_low  = clk_lo_q;
  assign ps2_data_drive_low = dat_lo_q;
  assign result_valid       = rv_q;
  assign result_error       = re_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Scaled clock (1 MHz) keeps inhibit at 120 and timeout at 15000 cycles.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 120;
  localparam int TMO = 15000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       command_valid = 1'b0;
  logic [7:0] command_byte = 8'h00;
  logic       command_ready;
  logic       clk_lo, dat_lo;
  logic       busy, result_valid, result_error;
  logic       dev_clk_lo = 1'b0;
  logic       dev_dat_lo = 1'b0;
  logic       clk_line, dat_line;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int rv_cnt = 0;
  logic rv_err = 1'b0;
  logic [1:0] rv_lines = 2'b00;
  logic rv_pend = 1'b0;
  logic rdy_after = 1'b0;

  assign clk_line = ~(clk_lo | dev_clk_lo);
  assign dat_line = ~(dat_lo | dev_dat_lo);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ(1_000_000),
    .INHIBIT_US(120),
    .TIMEOUT_US(15_000),
    .FILTER_CYCLES(8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .command_valid     (command_valid),
    .command_ready     (command_ready),
    .command_byte      (command_byte),
    .ps2_clk_in        (clk_line),
    .ps2_data_in       (dat_line),
    .ps2_clk_drive_low (clk_lo),
    .ps2_data_drive_low(dat_lo),
    .busy              (busy),
    .result_valid      (result_valid),
    .result_error      (result_error)
  );

  always @(posedge clk)
    if (command_valid && command_ready) acc_cnt++;

  always @(negedge clk) begin
    if (rv_pend) rdy_after = command_ready;
    rv_pend = result_valid;
    if (result_valid) begin
      rv_cnt++;
      rv_err = result_error;
      rv_lines = {clk_lo, dat_lo};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] b);
    @(negedge clk);
    command_valid = 1'b1;
    command_byte = b;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (busy) break;
    end
    chk("accept", busy, 1);
    command_valid = 1'b0;
  endtask

  task automatic wait_rts(output int hold);
    hold = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!clk_lo) break;
      hold++;
    end
  endtask

  task automatic dev_pulse(input logic data_low, output logic line);
    dev_dat_lo = data_low;
    repeat (5) @(negedge clk);
    dev_clk_lo = 1'b1;
    repeat (40) @(negedge clk);
    line = dat_line;
    dev_clk_lo = 1'b0;
    repeat (35) @(negedge clk);
  endtask

  task automatic device_xfer(input logic [7:0] b, input logic exp_par,
                             input logic ack, input logic exp_err,
                             input logic glitch, input logic skip_ready);
    int hold;
    int rv0;
    logic [10:0] bits;
    logic l;
    rv0 = rv_cnt;
    chk("busy_inh", busy, 1);
    wait_rts(hold);
    chk("inhibit_len", (hold >= INH && hold <= INH + 2), 1);
    chk("start_bit", dat_lo, 1);
    repeat (20) @(negedge clk);
    if (glitch) begin
      dev_clk_lo = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_lo = 1'b0;
      repeat (20) @(negedge clk);
    end
    for (int i = 0; i < 11; i++) begin
      dev_pulse((i == 10) && ack, l);
      bits[i] = l;
    end
    dev_dat_lo = 1'b0;
    chk("data_bits", bits[7:0], b);
    chk("parity", bits[8], exp_par);
    chk("stop", bits[9], 1);
    for (int i = 0; i < 200; i++) begin
      if (rv_cnt != rv0) break;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("result_seen", rv_cnt - rv0, 1);
    chk("result_err", rv_err, exp_err);
    chk("lines_rel", rv_lines, 0);
    if (!skip_ready) chk("ready_after", rdy_after, 1);
  endtask

  initial begin
    int hold;
    int rv0;
    int n;
    int a0;
    logic l;

    repeat (3) @(negedge clk);
    chk("rst_clk_lo", clk_lo, 0);
    chk("rst_dat_lo", dat_lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_re", result_error, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", command_ready, 1);

    start_cmd(PS2_CMD_SET_LEDS);
    device_xfer(8'hED, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    start_cmd(PS2_CMD_ENABLE);
    device_xfer(8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    start_cmd(8'h00);
    device_xfer(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    start_cmd(PS2_CMD_RESET);
    device_xfer(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // device never clocks
    start_cmd(PS2_CMD_ENABLE);
    wait_rts(hold);
    chk("to_inhibit_len", (hold >= INH && hold <= INH + 2), 1);
    rv0 = rv_cnt;
    n = 0;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      #1;
      n++;
      if (rv_cnt != rv0) break;
    end
    chk("to_cycles", (n >= TMO - 1 && n <= TMO + 1), 1);
    chk("to_err", rv_err, 1);
    chk("to_lines", rv_lines, 0);
    chk("to_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("to_ready", rdy_after, 1);

    // async reset while clock is inhibited
    start_cmd(PS2_CMD_SET_LEDS);
    repeat (10) @(negedge clk);
    chk("inh_clk_lo", clk_lo, 1);
    #2 reset = 1'b1;
    #1;
    chk("rinh_clk_lo", clk_lo, 0);
    chk("rinh_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rinh_ready", command_ready, 1);

    // async reset at device edge 5
    start_cmd(PS2_CMD_SET_LEDS);
    wait_rts(hold);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) dev_pulse(1'b0, l);
    repeat (5) @(negedge clk);
    dev_clk_lo = 1'b1;
    repeat (10) @(negedge clk);
    chk("e5_dat_lo", dat_lo, 1);
    #2 reset = 1'b1;
    #1;
    chk("e5_clk_lo", clk_lo, 0);
    chk("e5_dat_rel", dat_lo, 0);
    chk("e5_busy", busy, 0);
    dev_clk_lo = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("e5_ready", command_ready, 1);

    // second command offered while busy
    a0 = acc_cnt;
    start_cmd(PS2_CMD_ENABLE);
    command_valid = 1'b1;
    command_byte = 8'h00;
    device_xfer(8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", busy, 1);
    command_valid = 1'b0;
    device_xfer(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_accepts", acc_cnt - a0, 2);

`ifdef PS2_TX_FILTER_EN
    start_cmd(PS2_CMD_SET_LEDS);
    device_xfer(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
